// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channels and decode handshake.
`default_nettype none

interface instr_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic [6:0]  dec_opcode;
   logic [2:0]  dec_funct3;
   logic [6:0]  dec_funct7;
   logic [4:0]  dec_rd;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid, imem_rsp_data,
      output dec_valid, dec_instr, dec_pc, dec_opcode, dec_funct3, dec_funct7,
      output dec_rd, dec_rs1, dec_rs2,
      input  dec_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid, imem_rsp_data,
      input  dec_valid, dec_instr, dec_pc, dec_opcode, dec_funct3, dec_funct7,
      input  dec_rd, dec_rs1, dec_rs2,
      output dec_ready
   );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, credit-limited imem requests, response FIFO, redirect/fault handling.
// Optional performance counters enabled with `define IFETCH_PERF_EN.
`default_nettype none

module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        fetch_en,
   input  wire logic        redirect_valid,
   input  wire logic [31:0] redirect_pc,
   instr_fetch_if.master    bus,
   output logic             fetch_fault,
   output logic [31:0]      perf_fetched,
   output logic [31:0]      perf_dropped
);

   localparam int            CW      = $clog2(FIFO_DEPTH + 1);
   localparam int            PW      = $clog2(FIFO_DEPTH);
   localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t        state;
   logic [31:0]   pc;
   logic [31:0]   rsp_addr;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] count;
   logic [CW-1:0] drop_cnt;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   fifo_instr [FIFO_DEPTH];
   logic [31:0]   fifo_pc    [FIFO_DEPTH];

   logic redir, aligned, credit_ok, req_valid, req_fire, rsp_acc, keep, dec_fire, head_valid;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_P) ? '0 : p + PW'(1);
   endfunction

   assign redir      = redirect_valid && (state != IDLE);
   assign aligned    = (redirect_pc[1:0] == 2'b00);
   assign credit_ok  = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_W;
   assign req_valid  = (state == RUN) && fetch_en && !redirect_valid && credit_ok;
   assign req_fire   = req_valid && bus.imem_req_ready;
   // With nothing outstanding a response cannot belong to us, so it is ignored outright.
   assign rsp_acc    = bus.imem_rsp_valid && (outstanding != '0);
   assign keep       = rsp_acc && !redir && (drop_cnt == '0);
   assign head_valid = (count != '0);
   assign dec_fire   = head_valid && bus.dec_ready;

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc;
   assign bus.dec_valid      = head_valid;
   assign bus.dec_instr      = head_valid ? fifo_instr[rd_ptr] : 32'h0;
   assign bus.dec_pc         = head_valid ? fifo_pc[rd_ptr]    : 32'h0;
   assign bus.dec_opcode     = bus.dec_instr[6:0];
   assign bus.dec_funct3     = bus.dec_instr[14:12];
   assign bus.dec_funct7     = bus.dec_instr[31:25];
   assign bus.dec_rd         = bus.dec_instr[11:7];
   assign bus.dec_rs1        = bus.dec_instr[19:15];
   assign bus.dec_rs2        = bus.dec_instr[24:20];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         fetch_fault <= 1'b0;
         pc          <= RESET_PC;
         rsp_addr    <= RESET_PC;
         outstanding <= '0;
         count       <= '0;
         drop_cnt    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fetch_en) state <= RUN;
            end
            RUN: begin
               if (redir && !aligned) begin
                  state       <= FAULT;
                  fetch_fault <= 1'b1;
               end
            end
            FAULT: begin
               if (redir && aligned) begin
                  state       <= RUN;
                  fetch_fault <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               fetch_fault <= 1'b0;
            end
         endcase

         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_acc);

         if (redir) begin
            drop_cnt <= outstanding - CW'(rsp_acc);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (rsp_acc && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
            count <= count + CW'(keep) - CW'(dec_fire);
            if (dec_fire) rd_ptr <= ptr_inc(rd_ptr);
            if (keep) wr_ptr <= ptr_inc(wr_ptr);
         end

         if (redir && aligned) begin
            pc       <= redirect_pc;
            rsp_addr <= redirect_pc;
         end else begin
            if (req_fire) pc <= pc + 32'd4;
            if (keep) rsp_addr <= rsp_addr + 32'd4;
         end
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (keep) begin
         fifo_instr[wr_ptr] <= bus.imem_rsp_data;
         fifo_pc[wr_ptr]    <= rsp_addr;
      end
   end

`ifdef IFETCH_PERF_EN
   logic [31:0] flushed;
   assign flushed = redir ? (32'(count) - 32'(dec_fire)) : 32'h0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetched <= 32'h0;
         perf_dropped <= 32'h0;
      end else begin
         perf_fetched <= perf_fetched + 32'(keep);
         perf_dropped <= perf_dropped + 32'(rsp_acc && !keep) + flushed;
      end
   end
`else
   assign perf_fetched = 32'h0;
   assign perf_dropped = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// Directed scoreboard testbench for instr_fetch with a latency-configurable memory model.
`default_nettype none

module tb_instr_fetch;

`ifdef IFETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_fault, fetch_fault1;
   logic [31:0] perf_fetched, perf_dropped, perf_fetched1, perf_dropped1;

   instr_fetch_if bus ();
   instr_fetch_if bus1 ();

   instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .bus(bus), .fetch_fault(fetch_fault),
      .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut1 (
      .clk(clk), .reset(reset), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .bus(bus1), .fetch_fault(fetch_fault1),
      .perf_fetched(perf_fetched1), .perf_dropped(perf_dropped1)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h00B5_0533;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   // Memory model for dut: in-order responses, fixed latency in cycles.
   int          lat = 1;
   int          cyc = 0;
   int          req_cnt = 0;
   bit          spurious = 1'b0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] req_log[$];

   initial begin : mem_model
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (!reset) begin
            pend_addr.delete();
            pend_due.delete();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
         end else if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
         end else if (spurious) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
            spurious = 1'b0;
         end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
         end
         @(negedge clk);
         if (reset && bus.imem_req_valid && bus.imem_req_ready) begin
            pend_addr.push_back(bus.imem_req_addr);
            pend_due.push_back(cyc + lat);
            req_log.push_back(bus.imem_req_addr);
            req_cnt++;
         end
      end
   end

   // Single-cycle responder for dut1 (wrap-around PC instance).
   bit          fire1 = 1'b0;
   logic [31:0] req_log1[$];

   initial begin : mem1_model
      bus1.imem_req_ready = 1'b1;
      bus1.imem_rsp_valid = 1'b0;
      bus1.imem_rsp_data  = 32'h0;
      bus1.dec_ready      = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus1.imem_rsp_valid = fire1 && reset;
         bus1.imem_rsp_data  = 32'h0000_0013;
         @(negedge clk);
         fire1 = reset && bus1.imem_req_valid;
         if (fire1) req_log1.push_back(bus1.imem_req_addr);
      end
   end

   // Scoreboard: expected decode PCs, popped on each decode handshake.
   logic [31:0] exp_q[$];
   int          extras = 0;
   logic [31:0] mon_e, mon_w;

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (reset && bus.dec_valid && bus.dec_ready) begin
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               mon_w = mem_word(mon_e);
               chk("dec_pc", bus.dec_pc, mon_e);
               chk("dec_instr", bus.dec_instr, mon_w);
               chk("dec_opcode", 32'(bus.dec_opcode), 32'(mon_w[6:0]));
               chk("dec_funct3", 32'(bus.dec_funct3), 32'(mon_w[14:12]));
               chk("dec_funct7", 32'(bus.dec_funct7), 32'(mon_w[31:25]));
               chk("dec_rd", 32'(bus.dec_rd), 32'(mon_w[11:7]));
               chk("dec_rs1", 32'(bus.dec_rs1), 32'(mon_w[19:15]));
               chk("dec_rs2", 32'(bus.dec_rs2), 32'(mon_w[24:20]));
            end else begin
               extras++;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      reset          = 1'b0;
      fetch_en       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      bus.dec_ready  = 1'b0;
      step(2);
      reset   = 1'b1;
      req_cnt = 0;
      req_log.delete();
      exp_q.delete();
      step(1);
   endtask

   task automatic redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      step(1);
      redirect_valid = 1'b0;
   endtask

   int          k;
   int          snap;
   logic [31:0] pd_snap;

   initial begin
      reset          = 1'b0;
      fetch_en       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      bus.dec_ready  = 1'b0;
      step(2);

      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
      chk("rst_req_addr", bus.imem_req_addr, 32'h0);
      chk("rst_dec_valid", 32'(bus.dec_valid), 32'h0);
      chk("rst_dec_instr", bus.dec_instr, 32'h0);
      chk("rst_fault", 32'(fetch_fault), 32'h0);
      chk("rst_perf_fetched", perf_fetched, 32'h0);
      chk("rst_perf_dropped", perf_dropped, 32'h0);
      chk("rst_req_addr1", bus1.imem_req_addr, 32'hFFFF_FFF8);

      // Basic fetch with 1-cycle memory, decode stalled.
      reset    = 1'b1;
      lat      = 1;
      fetch_en = 1'b1;
      k = 0;
      while (!bus.imem_rsp_valid && k < 20) begin step(1); k++; end
      chk("first_rsp_seen", 32'(bus.imem_rsp_valid), 32'h1);
      chk("dec_valid_rsp_cycle", 32'(bus.dec_valid), 32'h0);
      step(1);
      chk("dec_valid_next", 32'(bus.dec_valid), 32'h1);
      chk("head_pc", bus.dec_pc, 32'h0);
      chk("head_instr", bus.dec_instr, 32'h00B5_0533);
      chk("head_opcode", 32'(bus.dec_opcode), 32'(7'b0110011));
      chk("head_funct3", 32'(bus.dec_funct3), 32'h0);
      step(8);
      chk("stall_req_cnt", 32'(req_cnt), 32'd2);
      chk("stall_req_valid", 32'(bus.imem_req_valid), 32'h0);
      chk("wrap_req_n", 32'(req_log1.size() >= 3), 32'h1);
      chk("wrap_req0", req_log1[0], 32'hFFFF_FFF8);
      chk("wrap_req1", req_log1[1], 32'hFFFF_FFFC);
      chk("wrap_req2", req_log1[2], 32'h0000_0000);

      for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
      bus.dec_ready = 1'b1;
      step(30);
      chk("stream_drained", 32'(exp_q.size()), 32'h0);
      chk("resume_req", 32'(req_cnt > 2), 32'h1);
      for (int i = 0; i < 4; i++) chk("req_addr_seq", req_log[i], 32'(i * 4));

      // Redirect with two stale requests in flight, 3-cycle memory.
      do_reset();
      lat           = 3;
      bus.dec_ready = 1'b1;
      fetch_en      = 1'b1;
      k = 0;
      while (req_cnt < 2 && k < 20) begin step(1); k++; end
      chk("two_outstanding", 32'(req_cnt), 32'd2);
      redirect(32'h100);
      exp_q.delete();
      exp_q.push_back(32'h100);
      exp_q.push_back(32'h104);
      exp_q.push_back(32'h108);
      step(20);
      chk("redir_drained", 32'(exp_q.size()), 32'h0);
      chk("perf_dropped_stale", perf_dropped, PERF ? 32'd2 : 32'd0);

      // Misaligned redirect enters FAULT; aligned redirect recovers.
      redirect(32'h102);
      exp_q.delete();
      extras = 0;
      snap   = req_cnt;
      chk("fault_flag", 32'(fetch_fault), 32'h1);
      chk("fault_no_req", 32'(bus.imem_req_valid), 32'h0);
      step(8);
      chk("fault_hold", 32'(fetch_fault), 32'h1);
      chk("fault_req_cnt", 32'(req_cnt), 32'(snap));
      chk("fault_no_decode", 32'(extras), 32'h0);
      chk("fault_dec_valid", 32'(bus.dec_valid), 32'h0);
      req_log.delete();
      exp_q.push_back(32'h200);
      exp_q.push_back(32'h204);
      redirect(32'h200);
      chk("fault_cleared", 32'(fetch_fault), 32'h0);
      chk("recover_addr", bus.imem_req_addr, 32'h200);
      step(20);
      chk("recover_first_req", req_log[0], 32'h200);
      chk("recover_drained", 32'(exp_q.size()), 32'h0);

      // Redirect coinciding with a decode handshake and a response.
      fetch_en = 1'b0;
      step(10);
      lat = 1;
      exp_q.delete();
      fetch_en = 1'b1;
      k = 0;
      while (!(bus.dec_valid && bus.dec_ready && bus.imem_rsp_valid) && k < 30) begin step(1); k++; end
      chk("samecycle_found", 32'(bus.dec_valid && bus.dec_ready && bus.imem_rsp_valid), 32'h1);
      pd_snap = perf_dropped;
      redirect(32'h300);
      exp_q.delete();
      exp_q.push_back(32'h300);
      exp_q.push_back(32'h304);
      exp_q.push_back(32'h308);
      step(15);
      chk("samecycle_drained", 32'(exp_q.size()), 32'h0);
      chk("samecycle_dropped", perf_dropped - pd_snap, PERF ? 32'd1 : 32'd0);

      // Asynchronous reset in the middle of a burst.
      #1;
      reset = 1'b0;
      #1;
      chk("arst_req_valid", 32'(bus.imem_req_valid), 32'h0);
      chk("arst_req_addr", bus.imem_req_addr, 32'h0);
      chk("arst_dec_valid", 32'(bus.dec_valid), 32'h0);
      chk("arst_dec_instr", bus.dec_instr, 32'h0);
      chk("arst_dec_pc", bus.dec_pc, 32'h0);
      chk("arst_fault", 32'(fetch_fault), 32'h0);
      chk("arst_perf_fetched", perf_fetched, 32'h0);
      chk("arst_perf_dropped", perf_dropped, 32'h0);
      chk("arst_req_addr1", bus1.imem_req_addr, 32'hFFFF_FFF8);
      chk("arst_req_valid1", 32'(bus1.imem_req_valid), 32'h0);
      fetch_en = 1'b0;
      step(2);
      reset = 1'b1;
      step(1);
      spurious = 1'b1;
      step(3);
      chk("spurious_ignored", 32'(bus.dec_valid), 32'h0);
      chk("idle_no_req", 32'(bus.imem_req_valid), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the simplified RISC-V core. It maintains the PC, issues word reads to instruction memory with a valid/ready request channel, and buffers in-order responses in a small FIFO. It presents each fetched instruction, with the opcode, funct3, funct7 and register fields already split out, to the control unit and decode stage through a valid/ready handshake. It accepts PC redirects from the branch/jump logic and discards any in-flight responses made stale by a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries. Also the maximum number of outstanding requests. Legal values are 2 to 8.
- `clk`, in, 1: clock. All state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `fetch_en`, in, 1: leaves IDLE when high.
- `imem_req_valid`, out, 1; `imem_req_ready`, in, 1; `imem_req_addr`, out, 32: request channel.
- `imem_rsp_valid`, in, 1; `imem_rsp_data`, in, 32: response channel. Responses return in order with latency of at least 1 cycle and have no backpressure.
- `redirect_valid`, in, 1; `redirect_pc`, in, 32: branch/jump target.
- `dec_valid`, out, 1; `dec_ready`, in, 1: decode handshake.
- `dec_instr`, out, 32; `dec_pc`, out, 32: FIFO head instruction and its address.
- `dec_opcode`, out, 7 = instr[6:0]; `dec_funct3`, out, 3 = instr[14:12]; `dec_funct7`, out, 7 = instr[31:25].
- `dec_rd`, out, 5; `dec_rs1`, out, 5; `dec_rs2`, out, 5: instr[11:7], [19:15], [24:20].
- `fetch_fault`, out, 1: misaligned redirect target.
- `perf_fetched`, out, 32; `perf_dropped`, out, 32: see Configuration.

## Operation
- States:
  - IDLE: reset state, no requests. Moves to RUN when `fetch_en`=1.
  - RUN: fetching.
  - FAULT: no requests, `fetch_fault`=1.
- `fetch_en` low while in RUN: stop issuing new requests, stay in RUN. The FIFO still drains and responses are still accepted.
- Credits:
  - `outstanding` counts accepted requests not yet responded. `count` is FIFO occupancy. Both counters are clog2(FIFO_DEPTH+1) bits wide.
  - `imem_req_valid` = RUN & `fetch_en` & !`redirect_valid` & (`outstanding` + `count` < FIFO_DEPTH).
  - `imem_req_addr` = `pc`.
- Request fire (valid & ready): `pc` += 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0. `outstanding` increments.
- Response:
  - `outstanding` decrements.
  - If `drop_cnt` > 0: discard the response and decrement `drop_cnt`.
  - Otherwise push {`rsp_addr`, data} into the FIFO. `rsp_addr` is a second address counter advanced per kept response.
  - The credit rule guarantees the FIFO never overflows.
- Decode fire (`dec_valid` & `dec_ready`): pop the head. `dec_valid` = (`count` != 0). Field outputs are pure slices of the head entry.
- Redirect (`redirect_valid`=1, any state except IDLE):
  - A decode handshake completing in the same cycle counts as consumed. All other FIFO entries are flushed, so `count` becomes 0.
  - A response arriving in the redirect cycle is discarded.
  - `drop_cnt` is set to `outstanding` after that cycle's response is counted. A request is never fired in this cycle.
  - If `redirect_pc`[1:0] == 0: `pc` and `rsp_addr` load `redirect_pc`, next state is RUN.
  - Otherwise: next state is FAULT and `pc` is unchanged.
- FAULT exits only on an aligned redirect. Responses still drain and are discarded.
- `redirect_valid` in IDLE is ignored.

## Timing
- Reset values:
  - `pc` = `rsp_addr` = RESET_PC.
  - `outstanding` = `count` = `drop_cnt` = 0; state IDLE.
  - Every output is 0 except `imem_req_addr`, which equals RESET_PC.
- Reset mid-operation aborts everything immediately. Responses arriving after reset release are not accepted, because `outstanding`=0 means any response is dropped (`imem_rsp_valid` is ignored when `outstanding`=0).
- Request to issue: `imem_req_valid` can assert the cycle after entering RUN.
- Response to decode: a response in cycle N with an empty FIFO gives `dec_valid`=1 in cycle N+1. There is no combinational path from `imem_rsp_*` to `dec_*`.
- Redirect to new request: a redirect in cycle N gives `imem_req_addr` = `redirect_pc` with `imem_req_valid` possible in cycle N+1.
- Push and pop in the same cycle is legal; `count` is unchanged.
- `imem_req_valid` may drop without handshake only due to `redirect_valid`, a state change, or `fetch_en` low. `imem_req_addr` is stable while valid is high and ready is low.

## Configuration
- `IFETCH_PERF_EN` defined:
  - `perf_fetched` increments on every FIFO push.
  - `perf_dropped` increments on every discarded response or flushed FIFO entry, adding the entry count in a single cycle.
  - Both counters wrap at 2^32 and reset to 0.
- Not defined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Reset, `fetch_en`=1, memory with 1-cycle latency and ready always high:
  - Requests go to 0x0, 0x4, 0x8, …
  - With `dec_ready`=1, the instructions appear in order.
  - `dec_opcode`=7'b0110011 and `dec_funct3`=3'b000 for word 0x00B50533.
- `dec_ready`=0 with FIFO_DEPTH=2:
  - Exactly 2 requests issue, then `imem_req_valid` stays low.
  - Releasing `dec_ready` resumes issuing.
- 3-cycle memory latency with 2 outstanding, then redirect to 0x100:
  - Both stale responses are discarded (`perf_dropped`=2).
  - The next `dec_pc` is 0x100.
- Redirect to 0x102: `fetch_fault`=1 and no requests. A later redirect to 0x200 clears the fault, and the next fetch is at 0x200.
- Redirect in the same cycle as a decode handshake and a response: the handshake entry is consumed, and the response is dropped.
- `RESET_PC`=32'hFFFF_FFF8: fetches go to 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0. Asserting reset mid-burst returns all outputs to their reset values asynchronously.
